// File: rtl/seq_multiplier.sv
// Sequential add-shift multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// One ADD and one SHIFT step per multiplier bit; the signed mode subtracts on the final step.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_Load_Clear,
  input  logic               Run,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   A_in,
  input  logic [WIDTH-1:0]   B_in,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             x_q;
  logic [CW-1:0]    cnt;
  logic             mode;

  logic             last;
  logic [WIDTH:0]   ext_a, ext_s, sum;

  assign last  = (cnt == CW'(WIDTH - 1));
  assign ext_a = {mode & a_q[WIDTH-1], a_q};
  assign ext_s = {mode & s_q[WIDTH-1], s_q};
  // The sign bit of a two's-complement multiplier carries negative weight.
  assign sum   = (mode && last) ? (ext_a - ext_s) : (ext_a + ext_s);

  assign Product = {a_q, b_q};

  always_ff @(posedge Clk) begin
    if (Reset_Load_Clear) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      x_q   <= 1'b0;
      cnt   <= '0;
      mode  <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Run) begin
            state <= LOAD;
            Busy  <= 1'b1;
          end else begin
            Busy  <= 1'b0;
          end
        end
        LOAD: begin
          s_q   <= A_in;
          b_q   <= B_in;
          a_q   <= '0;
          x_q   <= 1'b0;
          cnt   <= '0;
          mode  <= Signed_Mode;
          state <= ADD;
          Busy  <= 1'b1;
          Done  <= 1'b0;
        end
        ADD: begin
          if (b_q[0]) {x_q, a_q} <= sum;
          state <= SHIFT;
          Busy  <= 1'b1;
          Done  <= 1'b0;
        end
        SHIFT: begin
          // Arithmetic shift in signed mode keeps X; unsigned shifts in zero.
          x_q <= mode ? x_q : 1'b0;
          a_q <= {x_q, a_q[WIDTH-1:1]};
          b_q <= {a_q[0], b_q[WIDTH-1:1]};
          if (last) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
            Busy  <= 1'b1;
            Done  <= 1'b0;
          end
        end
        DONE: begin
          Busy <= 1'b0;
          if (Run) begin
            Done  <= 1'b1;
          end else begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboarded random + directed bench for seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic        rst8, run8, m8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        rst4, run4, m4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset_Load_Clear(rst8), .Run(run8), .Signed_Mode(m8),
    .A_in(a8), .B_in(b8), .Product(p8), .Busy(busy8), .Done(done8));

  seq_multiplier #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Reset_Load_Clear(rst4), .Run(run4), .Signed_Mode(m4),
    .A_in(a4), .B_in(b4), .Product(p4), .Busy(busy4), .Done(done4));

  typedef struct {
    longint p;
    int     t0;
    int     t1;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Plain integer multiply of the interpreted operands, truncated to 2*w bits.
  function automatic longint ref_mul(input longint a, input longint b, input bit m, input int w);
    longint sa, sb, one;
    one = 1;
    sa = a;
    sb = b;
    if (m && a >= (one << (w - 1))) sa = a - (one << w);
    if (m && b >= (one << (w - 1))) sb = b - (one << w);
    return (sa * sb) & ((one << (2 * w)) - 1);
  endfunction

  // Monitors: compare the product and the Done latency on each Done rising edge.
  bit done8_q = 1'b0, busy_err8 = 1'b0;
  always @(negedge Clk) begin
    if (q8.size() > 0 && cyc >= q8[0].t0 && cyc < q8[0].t1 && (!busy8 || done8))
      busy_err8 = 1'b1;
    if (done8 && !done8_q) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL w8_unexpected_done: got Done=1 expected no pending op");
      end else begin
        chk("w8_product", longint'(p8), q8[0].p);
        chk("w8_latency", longint'(cyc), longint'(q8[0].t1));
        chk("w8_busy_window", longint'(busy_err8), 0);
        void'(q8.pop_front());
      end
      busy_err8 = 1'b0;
    end
    done8_q = done8;
  end

  bit done4_q = 1'b0, busy_err4 = 1'b0;
  always @(negedge Clk) begin
    if (q4.size() > 0 && cyc >= q4[0].t0 && cyc < q4[0].t1 && (!busy4 || done4))
      busy_err4 = 1'b1;
    if (done4 && !done4_q) begin
      if (q4.size() == 0) begin
        total++;
        $display("FAIL w4_unexpected_done: got Done=1 expected no pending op");
      end else begin
        chk("w4_product", longint'(p4), q4[0].p);
        chk("w4_latency", longint'(cyc), longint'(q4[0].t1));
        chk("w4_busy_window", longint'(busy_err4), 0);
        void'(q4.pop_front());
      end
      busy_err4 = 1'b0;
    end
    done4_q = done4;
  end

  // Issue one WIDTH=8 operation; returns at the negedge where Done is first seen.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit m,
                     input bit hold, input bit scr, input bit wait_done);
    exp_t e;
    @(negedge Clk);
    a8 = a; b8 = b; m8 = m; run8 = 1'b1;
    @(posedge Clk); #1;
    e.p = ref_mul(longint'(a), longint'(b), m, 8);
    e.t0 = cyc;
    e.t1 = cyc + 17;
    q8.push_back(e);
    if (!hold) begin @(negedge Clk); run8 = 1'b0; end
    if (wait_done) begin
      for (int k = 0; k < 60; k++) begin
        @(negedge Clk);
        if (scr) begin
          a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
        end
        if (done8) break;
        if (k == 59) begin
          total++;
          $display("FAIL w8_timeout: got no Done expected Done within 60 cycles");
        end
      end
    end
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input bit m);
    exp_t e;
    @(negedge Clk);
    a4 = a; b4 = b; m4 = m; run4 = 1'b1;
    @(posedge Clk); #1;
    e.p = ref_mul(longint'(a), longint'(b), m, 4);
    e.t0 = cyc;
    e.t1 = cyc + 9;
    q4.push_back(e);
    @(negedge Clk); run4 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (done4) break;
      if (k == 39) begin
        total++;
        $display("FAIL w4_timeout: got no Done expected Done within 40 cycles");
      end
    end
  endtask

  initial begin
    longint held;
    int t0;
    bit bad;
    rst8 = 1'b1; run8 = 1'b1; m8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b1; run4 = 1'b0; m4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge Clk);
    // Reset held alongside Run must keep the block idle.
    chk("reset_product", longint'(p8), 0);
    chk("reset_busy", longint'(busy8), 0);
    chk("reset_done", longint'(done8), 0);
    rst8 = 1'b0; run8 = 1'b0; rst4 = 1'b0;
    @(negedge Clk);
    chk("idle_after_reset_busy", longint'(busy8), 0);

    // Directed corner operands.
    go8(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    go8(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    go8(8'h07, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b1);
    go8(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    go8(8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("direct_0x00x0x80", longint'(p8), 0);

    // Run held through DONE: no retrigger, then drop and hold result in IDLE.
    go8(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
    held = ref_mul(64'h5A, 64'hC3, 1'b0, 8);
    bad = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (!done8 || busy8 || longint'(p8) != held) bad = 1'b1;
    end
    chk("hold_run_no_reload", longint'(bad), 0);
    run8 = 1'b0;
    @(negedge Clk);
    chk("drop_run_done_low", longint'(done8), 0);
    @(negedge Clk);
    chk("idle_holds_product", longint'(p8), held);
    go8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);

    // Operands scrambled while busy must not affect the result.
    for (int i = 0; i < 6; i++)
      go8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b1);

    // Reset during the 5th SHIFT abandons the operation.
    go8(8'hAB, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b0);
    t0 = q8[0].t0;
    while (cyc < t0 + 10) @(negedge Clk);
    rst8 = 1'b1;
    q8.delete();
    @(negedge Clk);
    rst8 = 1'b0;
    chk("midreset_product", longint'(p8), 0);
    chk("midreset_busy", longint'(busy8), 0);
    chk("midreset_done", longint'(done8), 0);
    @(negedge Clk);
    chk("midreset_stays_idle", longint'(busy8), 0);
    go8(8'hAB, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++)
      go8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);

    // Narrow instance.
    go4(4'hF, 4'hF, 1'b0);
    go4(4'h8, 4'h7, 1'b1);
    go4(4'h8, 4'h8, 1'b1);
    for (int i = 0; i < 12; i++)
      go4(4'($urandom), 4'($urandom), 1'($urandom));

    repeat (3) @(negedge Clk);
    if (q8.size() != 0 || q4.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q8.size(), q4.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
